// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - multi-outstanding instruction fetcher with PC tag FIFO and instruction queue
// Optional build macro IFS_ADEL_CHECK_EN: a misaligned fetch PC yields one address-error entry and halts fetch.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'hbfc00000,
  parameter int          MAX_OUTST = 2,
  parameter int          QDEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  input  logic        ds_allowin,
  output logic        fs_to_ds_valid,
  output logic [64:0] fs_to_ds_bus,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic [31:0] inst_sram_rdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok
);
  localparam int CW  = $clog2(MAX_OUTST + 1);
  localparam int TAW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int QAW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int QCW = $clog2(QDEPTH + 1);

  logic [31:0]    fetch_pc, req_pc, addr_aligned;
  logic           req, stale;
  logic [CW-1:0]  outst, discard;
  logic [31:0]    tag_mem [MAX_OUTST];
  logic [TAW-1:0] tag_wp, tag_rp;
  logic [64:0]    q_mem [QDEPTH];
  logic [QAW-1:0] q_wp, q_rp;
  logic [QCW-1:0] q_count;

  logic           accept, resp, q_push, q_pop, adel_push, fetch_ok;
  logic           stale_n, issue_ok, req_n;
  logic [64:0]    q_wdata;
  logic [CW-1:0]  outst_n, discard_n;
  logic [QCW-1:0] q_count_n;
  logic [31:0]    fetch_pc_n, req_pc_n;

  function automatic logic [TAW-1:0] tag_inc(input logic [TAW-1:0] p);
    return (32'(p) == MAX_OUTST - 1) ? '0 : p + TAW'(1);
  endfunction

  function automatic logic [QAW-1:0] q_inc(input logic [QAW-1:0] p);
    return (32'(p) == QDEPTH - 1) ? '0 : p + QAW'(1);
  endfunction

`ifdef IFS_ADEL_CHECK_EN
  logic halted;
  assign fetch_ok     = (fetch_pc_n[1:0] == 2'b00);
  // Raised only once the pipe is empty so the error entry lands behind all valid fetches.
  assign adel_push    = !redirect_valid && !halted && (fetch_pc[1:0] != 2'b00) &&
                        (outst == '0) && !req && (32'(q_count) < QDEPTH);
  assign addr_aligned = req_pc;
  always_ff @(posedge clk) begin
    if (reset || redirect_valid) halted <= 1'b0;
    else if (adel_push)          halted <= 1'b1;
  end
`else
  assign fetch_ok     = 1'b1;
  assign adel_push    = 1'b0;
  assign addr_aligned = req_pc & 32'hffff_fffc;
`endif

  always_comb begin
    accept  = req && inst_sram_addr_ok;
    resp    = inst_sram_data_ok;
    q_pop   = fs_to_ds_valid && ds_allowin;
    q_push  = 1'b0;
    q_wdata = '0;
    if (resp && (discard == '0) && !redirect_valid) begin
      q_push  = 1'b1;
      q_wdata = {1'b0, inst_sram_rdata, tag_mem[tag_rp]};
    end else if (adel_push) begin
      q_push  = 1'b1;
      q_wdata = {1'b1, 32'b0, fetch_pc};
    end
    outst_n = outst + CW'(accept) - CW'(resp);
    if (redirect_valid) begin
      // Everything still owed by the bus after this edge belongs to the old stream.
      q_count_n  = '0;
      discard_n  = outst_n;
      stale_n    = req && !inst_sram_addr_ok;
      fetch_pc_n = redirect_pc;
    end else begin
      q_count_n  = q_count + QCW'(q_push) - QCW'(q_pop);
      discard_n  = discard + CW'(accept && stale) - CW'(resp && (discard != '0));
      stale_n    = stale && !accept;
      fetch_pc_n = (accept && !stale) ? fetch_pc + 32'd4 : fetch_pc;
    end
  end

  // Credit check on next-state counts so the queue can absorb every response in flight.
  always_comb begin
    issue_ok = !stall && !stale_n && fetch_ok && (32'(outst_n) < MAX_OUTST) &&
               (32'(outst_n) + 32'(q_count_n) < QDEPTH);
    req_n    = issue_ok;
    req_pc_n = fetch_pc_n;
    if (req && !inst_sram_addr_ok) begin
      req_n    = 1'b1;
      req_pc_n = req_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      req      <= 1'b0;
      stale    <= 1'b0;
      outst    <= '0;
      discard  <= '0;
      tag_wp   <= '0;
      tag_rp   <= '0;
      q_wp     <= '0;
      q_rp     <= '0;
      q_count  <= '0;
    end else begin
      fetch_pc <= fetch_pc_n;
      req_pc   <= req_pc_n;
      req      <= req_n;
      stale    <= stale_n;
      outst    <= outst_n;
      discard  <= discard_n;
      q_count  <= q_count_n;
      if (accept) tag_wp <= tag_inc(tag_wp);
      if (resp)   tag_rp <= tag_inc(tag_rp);
      if (redirect_valid) begin
        q_wp <= '0;
        q_rp <= '0;
      end else begin
        if (q_push) q_wp <= q_inc(q_wp);
        if (q_pop)  q_rp <= q_inc(q_rp);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) tag_mem[tag_wp] <= addr_aligned;
    if (q_push && !redirect_valid) q_mem[q_wp] <= q_wdata;
  end

  assign fs_to_ds_valid  = (q_count != '0);
  assign fs_to_ds_bus    = fs_to_ds_valid ? q_mem[q_rp] : '0;
  assign inst_sram_req   = req;
  assign inst_sram_addr  = addr_aligned;
  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'd2;
  assign inst_sram_wdata = 32'b0;
endmodule
